// File: rtl/fetch_port_arbiter.sv
// Round-robin arbiter sharing one instruction-memory fetch port between two fetch ways.
// One transaction in flight; a jump flush of the granted way cancels it and the late response is dropped.
module fetch_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              way0_request_i,
   input  logic [ADDR_W-1:0] way0_instAddr_i,
   input  logic              way0_jumpFlag_i,
   output logic [INST_W-1:0] way0_inst_o,
   output logic              way0_dataOk_o,
   input  logic              way1_request_i,
   input  logic [ADDR_W-1:0] way1_instAddr_i,
   input  logic              way1_jumpFlag_i,
   output logic [INST_W-1:0] way1_inst_o,
   output logic              way1_dataOk_o,
   output logic              mem_request_o,
   output logic [ADDR_W-1:0] mem_instAddr_o,
   input  logic [INST_W-1:0] mem_inst_i,
   input  logic              mem_dataOk_i
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} stateT;

   stateT state, nextState;
   logic  rr;
   logic  gnt;
   logic  anyReq;
   logic  grantWay;
   logic  flushGnt;
   logic  capture;

   assign anyReq   = way0_request_i | way1_request_i;
   // With both ways requesting the pointer decides; otherwise the lone requester wins.
   assign grantWay = (way0_request_i & way1_request_i) ? rr : way1_request_i;
   assign flushGnt = gnt ? way1_jumpFlag_i : way0_jumpFlag_i;
   assign capture  = (state == WAIT) && mem_dataOk_i && !flushGnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   always_comb begin
      // NOTE: default assignment first, so no path through the case can infer a latch.
      nextState = state;
      case (state)
         IDLE:  if (anyReq) nextState = ISSUE;
         ISSUE: nextState = flushGnt ? DRAIN : WAIT;
         WAIT: begin
            if (mem_dataOk_i)  nextState = flushGnt ? IDLE : RESP;
            else if (flushGnt) nextState = DRAIN;
         end
         RESP:  nextState = IDLE;
         DRAIN: if (mem_dataOk_i) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // A jump in the response cycle suppresses the pulse so the way never sees stale data.
   always_comb begin
      mem_request_o = (state == ISSUE);
      way0_dataOk_o = (state == RESP) && !gnt && !way0_jumpFlag_i;
      way1_dataOk_o = (state == RESP) &&  gnt && !way1_jumpFlag_i;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr             <= 1'b0;
         gnt            <= 1'b0;
         mem_instAddr_o <= '0;
         way0_inst_o    <= '0;
         way1_inst_o    <= '0;
      end else begin
         if (state == IDLE && anyReq) begin
            gnt            <= grantWay;
            rr             <= ~grantWay;
            mem_instAddr_o <= grantWay ? way1_instAddr_i : way0_instAddr_i;
         end
         if (capture && !gnt) way0_inst_o <= mem_inst_i;
         if (capture &&  gnt) way1_inst_o <= mem_inst_i;
      end
   end

endmodule
